// File: rtl/fp32_arb_pkg.sv
// Shared widths, FP32 constants, op encoding and helpers for the shared fp32 adder arbiter.
package fp32_arb_pkg;

    localparam int unsigned FP32_W = 32;
    localparam int unsigned EXT_W  = 27;

    localparam logic [FP32_W-1:0] FP32_ONE   = 32'h3F80_0000;
    localparam logic [FP32_W-1:0] FP32_TWO   = 32'h4000_0000;
    localparam logic [FP32_W-1:0] FP32_THREE = 32'h4040_0000;
    localparam logic [FP32_W-1:0] FP32_FIVE  = 32'h40A0_0000;
    localparam logic [FP32_W-1:0] FP32_QNAN  = 32'h7FC0_0000;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Leading-zero count of the extended mantissa (27 when all zero).
    function automatic logic [4:0] lzc27(input logic [EXT_W-1:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

endpackage

// File: rtl/fp32_add.sv
// Combinational IEEE-754 single-precision add/subtract, round-to-nearest-even.
module fp32_add
    import fp32_arb_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    input  logic              sub,
    output logic [FP32_W-1:0] y_c
);

    logic        sb_eff, sx, sy, eff_sub;
    logic        a_nan, b_nan, a_inf, b_inf, rnd;
    logic [30:0] xb, yb;
    logic [9:0]  ex, ey, d, sham, e_n, e_fin;
    logic [23:0] mx, my;
    logic [5:0]  dsh;
    logic [71:0] sh;
    logic [26:0] ya, m;
    logic [27:0] s;
    logic [4:0]  lz;
    logic [24:0] mr;
    logic [22:0] frac;

    always_comb begin
        y_c     = '0;
        sb_eff  = b[31] ^ (sub == OP_SUB);
        a_nan   = (&a[30:23]) & (|a[22:0]);
        b_nan   = (&b[30:23]) & (|b[22:0]);
        a_inf   = (&a[30:23]) & ~(|a[22:0]);
        b_inf   = (&b[30:23]) & ~(|b[22:0]);
        lz      = '0;
        sham    = '0;
        m       = '0;
        e_n     = '0;
        e_fin   = '0;
        frac    = '0;

        // Order operands by magnitude so the subtraction result is never negative.
        if (a[30:0] >= b[30:0]) begin
            xb = a[30:0]; sx = a[31];
            yb = b[30:0]; sy = sb_eff;
        end else begin
            xb = b[30:0]; sx = sb_eff;
            yb = a[30:0]; sy = a[31];
        end
        eff_sub = sx ^ sy;

        ex = (xb[30:23] == 8'd0) ? 10'd1 : {2'b00, xb[30:23]};
        ey = (yb[30:23] == 8'd0) ? 10'd1 : {2'b00, yb[30:23]};
        mx = {|xb[30:23], xb[22:0]};
        my = {|yb[30:23], yb[22:0]};
        d  = ex - ey;

        // Align with guard, round and sticky bits.
        dsh = (d > 10'd48) ? 6'd48 : d[5:0];
        sh  = {my, 48'b0} >> dsh;
        ya  = {sh[71:46], sh[45] | (|sh[44:0])};

        s = eff_sub ? ({1'b0, mx, 3'b000} - {1'b0, ya})
                    : ({1'b0, mx, 3'b000} + {1'b0, ya});

        if (s[27]) begin
            m   = {s[27:2], s[1] | s[0]};
            e_n = ex + 10'd1;
        end else begin
            lz   = lzc27(s[26:0]);
            sham = (10'(lz) < ex) ? 10'(lz) : (ex - 10'd1);
            m    = s[26:0] << sham;
            e_n  = ex - sham;
        end

        rnd = m[2] & (m[1] | m[0] | m[3]);
        mr  = {1'b0, m[26:3]} + 25'(rnd);
        if (mr[24]) begin
            e_fin = e_n + 10'd1;
            frac  = mr[23:1];
        end else begin
            e_fin = mr[23] ? e_n : 10'd0;
            frac  = mr[22:0];
        end

        if (e_fin >= 10'd255) y_c = {sx, 8'hFF, 23'd0};
        else                  y_c = {sx, e_fin[7:0], frac};

        // Exact cancellation yields +0; only like-signed zeros keep their sign.
        if (s == 28'd0) y_c = {eff_sub ? 1'b0 : sx, 31'd0};

        if (a_nan || b_nan)                         y_c = FP32_QNAN;
        else if (a_inf && b_inf && (a[31] != sb_eff)) y_c = FP32_QNAN;
        else if (a_inf)                             y_c = a;
        else if (b_inf)                             y_c = {sb_eff, b[30:0]};
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant scanning upward from ptr+1, pointer moves on accept.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    input  logic [IDX_W-1:0] winner,
    output logic [N-1:0]     grant
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;

    // First requester after the last winner, wrapping modulo N.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!found && req[(32'(ptr_q) + k) % N]) begin
                grant[(32'(ptr_q) + k) % N] = 1'b1;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = winner;
    end

    // Reset to N-1 so requester 0 is first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= IDX_W'(N - 1);
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fp32_add_arbiter.sv
// Round-robin sharing of one fp32 adder among NUM_REQ requesters with a fixed-latency tagged result stream.
module fp32_add_arbiter
    import fp32_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*FP32_W-1:0]   req_a,
    input  logic [NUM_REQ*FP32_W-1:0]   req_b,
    input  logic [NUM_REQ-1:0]          req_sub,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [ID_W-1:0]             res_id,
    output logic [FP32_W-1:0]           res_data,
    output logic                        busy
);

    logic [NUM_REQ-1:0] grant;
    logic               stall_c, advance_c, hs_c, win_sub_c;
    logic [ID_W-1:0]    win_c;
    logic [FP32_W-1:0]  win_a_c, win_b_c, add_y_c;

    logic [FP32_W-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic               s1_sub_q, s1_sub_d;
    logic [LATENCY-1:0] v_q, v_d;
    logic [ID_W-1:0]    id_q [LATENCY];
    logic [ID_W-1:0]    id_d [LATENCY];
    logic               busy_q, busy_d;

    assign stall_c   = res_valid & ~res_ready;
    assign advance_c = ~stall_c;
    assign req_ready = grant & {NUM_REQ{advance_c & rst_n}};

    // Winner index and operand mux from the one-hot accept.
    always_comb begin
        hs_c      = |(req_valid & req_ready);
        win_c     = '0;
        win_a_c   = '0;
        win_b_c   = '0;
        win_sub_c = OP_ADD;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                win_c     = ID_W'(i);
                win_a_c   = req_a[FP32_W*i +: FP32_W];
                win_b_c   = req_b[FP32_W*i +: FP32_W];
                win_sub_c = req_sub[i];
            end
        end
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (hs_c),
        .winner  (win_c),
        .grant   (grant)
    );

    // Stage 1 captures operands on accept; all stages shift together unless stalled.
    always_comb begin
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_sub_d = s1_sub_q;
        v_d      = v_q;
        id_d     = id_q;
        if (advance_c) begin
            v_d[0] = hs_c;
            if (hs_c) begin
                s1_a_d   = win_a_c;
                s1_b_d   = win_b_c;
                s1_sub_d = win_sub_c;
                id_d[0]  = win_c;
            end
            for (int unsigned k = 1; k < LATENCY; k++) begin
                v_d[k]  = v_q[k-1];
                id_d[k] = id_q[k-1];
            end
        end
        busy_d = |v_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_sub_q <= OP_ADD;
            v_q      <= '0;
            busy_q   <= 1'b0;
            for (int unsigned k = 0; k < LATENCY; k++) id_q[k] <= '0;
        end else begin
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_sub_q <= s1_sub_d;
            v_q      <= v_d;
            busy_q   <= busy_d;
            id_q     <= id_d;
        end
    end

    fp32_add u_add (
        .a   (s1_a_q),
        .b   (s1_b_q),
        .sub (s1_sub_q),
        .y_c (add_y_c)
    );

    generate
        if (LATENCY == 1) begin : g_lat1
            assign res_data = add_y_c;
        end else begin : g_latn
            logic [FP32_W-1:0] dat_q [LATENCY-1];
            logic [FP32_W-1:0] dat_d [LATENCY-1];

            always_comb begin
                dat_d = dat_q;
                if (advance_c) begin
                    dat_d[0] = add_y_c;
                    for (int unsigned k = 1; k < LATENCY - 1; k++) dat_d[k] = dat_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned k = 0; k < LATENCY - 1; k++) dat_q[k] <= '0;
                end else begin
                    dat_q <= dat_d;
                end
            end

            assign res_data = dat_q[LATENCY-2];
        end
    endgenerate

    assign res_valid = v_q[LATENCY-1];
    assign res_id    = id_q[LATENCY-1];
    assign busy      = busy_q;

endmodule

// File: tb/tb_fp32_add_arbiter.sv
// Randomized and directed bench for fp32_add_arbiter against an integer-valued behavioural model.
module tb_fp32_add_arbiter;
    import fp32_arb_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid, req_ready, req_sub;
    logic [N*32-1:0]   req_a, req_b;
    logic              res_valid, res_ready, busy;
    logic [IDW-1:0]    res_id;
    logic [31:0]       res_data;

    always #5 clk = ~clk;

    fp32_add_arbiter #(.NUM_REQ(N), .LATENCY(LAT), .ID_W(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .res_valid(res_valid),
        .res_ready(res_ready), .res_id(res_id), .res_data(res_data), .busy(busy)
    );

    typedef struct {bit v; int id; logic [31:0] d;} ent_t;
    ent_t pipe[$];
    int   ptr_m;
    int   pa[N], pb[N];
    bit   ps[N];
    int   total = 0, bad = 0;

    // Exact fp32 encoding of an integer with magnitude below 2^24.
    function automatic logic [31:0] i2f(int v);
        logic [31:0] mag, r;
        int p;
        if (v == 0) return 32'h0;
        mag = 32'(v < 0 ? -v : v);
        p = 0;
        for (int k = 0; k < 32; k++) if (mag[k]) p = k;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'(mag << (23 - p));
        return r;
    endfunction

    function automatic int rr_pick(logic [N-1:0] v, int ptr);
        for (int k = 1; k <= N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic int rnd_int();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 16)) - 8;
        return int'($urandom_range(0, 200000)) - 100000;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = i2f(pa[i]);
            req_b[32*i +: 32] = i2f(pb[i]);
            req_sub[i]        = ps[i];
        end
    endtask

    task automatic model_reset();
        ent_t e;
        e.v = 0; e.id = 0; e.d = 0;
        pipe = {};
        for (int k = 0; k < LAT; k++) pipe.push_back(e);
        ptr_m = N - 1;
    endtask

    task automatic new_op(int i);
        pa[i] = rnd_int();
        pb[i] = rnd_int();
        ps[i] = 1'($urandom_range(0, 1));
        req_valid[i] = 1'b1;
    endtask

    // One clock: check accept vector before the edge, advance model, check outputs after it.
    task automatic step(output int hs);
        ent_t e;
        bit   stall_m, any;
        int   g;
        drive_ops();
        @(negedge clk);
        stall_m = pipe[0].v && !res_ready;
        g = stall_m ? -1 : rr_pick(req_valid, ptr_m);
        chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        e.v  = (g >= 0);
        e.id = (g < 0) ? 0 : g;
        e.d  = (g < 0) ? 32'd0 : i2f(ps[e.id] ? pa[e.id] - pb[e.id] : pa[e.id] + pb[e.id]);
        hs = g;
        @(posedge clk);
        #1;
        if (!stall_m) begin
            void'(pipe.pop_front());
            pipe.push_back(e);
            if (g >= 0) ptr_m = g;
        end
        any = 0;
        foreach (pipe[k]) any |= pipe[k].v;
        chk("res_valid", 32'(res_valid), 32'(pipe[0].v));
        chk("busy", 32'(busy), 32'(any));
        if (pipe[0].v) begin
            chk("res_id", 32'(res_id), 32'(pipe[0].id));
            chk("res_data", res_data, pipe[0].d);
        end
    endtask

    task automatic step_drop(output int hs);
        step(hs);
        if (hs >= 0) req_valid[hs] = 1'b0;
    endtask

    int h;

    initial begin
        rst_n = 1'b0; res_ready = 1'b1; req_valid = '0;
        for (int i = 0; i < N; i++) begin pa[i] = 0; pb[i] = 0; ps[i] = 0; end
        drive_ops();
        model_reset();

        chk("i2f_one", i2f(1), FP32_ONE);
        chk("i2f_two", i2f(2), FP32_TWO);
        chk("i2f_three", i2f(3), FP32_THREE);
        chk("i2f_five", i2f(5), FP32_FIVE);

        repeat (2) @(posedge clk);
        #1 req_valid = '1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", 32'(res_id), 0);
        chk("rst_busy", 32'(busy), 0);
        req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single add on requester 0.
        pa[0] = 1; pb[0] = 2; ps[0] = 0; req_valid[0] = 1'b1;
        step_drop(h);
        chk("t1_grant", 32'(h), 0);
        chk("t1_early_valid", 32'(res_valid), 0);
        chk("t1_busy", 32'(busy), 1);
        step_drop(h);
        chk("t1_valid", 32'(res_valid), 1);
        chk("t1_data", res_data, 32'h4040_0000);
        chk("t1_id", 32'(res_id), 0);
        step_drop(h);
        chk("t1_busy_fall", 32'(busy), 0);

        // Subtract on requester 2.
        pa[2] = 5; pb[2] = 3; ps[2] = 1; req_valid[2] = 1'b1;
        step_drop(h);
        chk("t2_grant", 32'(h), 2);
        step_drop(h);
        chk("t2_data", res_data, 32'h4000_0000);
        chk("t2_id", 32'(res_id), 2);

        // Move pointer to 3 so the full rotation starts at requester 0.
        pa[3] = 7; pb[3] = 1; ps[3] = 0; req_valid[3] = 1'b1;
        step_drop(h);
        chk("t3_pre_grant", 32'(h), 3);
        for (int i = 0; i < N; i++) begin pa[i] = 10 * i + 1; pb[i] = i; ps[i] = 0; end
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            step(h);
            chk("t3_rr_order", 32'(h), 32'(k % N));
            if (h >= 0) begin pa[h] = 100 * k + h; pb[h] = -3 * k; ps[h] = 1'(k & 1); end
        end
        req_valid = '0;
        repeat (3) step(h);

        // Backpressure: four ops, result port held off for three cycles.
        for (int i = 0; i < N; i++) begin pa[i] = 1000 + i; pb[i] = 17 * i; ps[i] = 1'(i & 1); end
        req_valid = '1;
        for (int w = 0; w < 10 && !res_valid; w++) step_drop(h);
        chk("t4_valid_rose", 32'(res_valid), 1);
        res_ready = 1'b0;
        repeat (3) step_drop(h);
        chk("t4_stall_ready", 32'(req_ready), 0);
        res_ready = 1'b1;
        repeat (6) step_drop(h);
        chk("t4_drained", 32'(busy), 0);

        // Sparse: requester 3 withdraws before it is ever granted.
        pa[1] = 9; pb[1] = 4; ps[1] = 0; pa[3] = 8; pb[3] = 8; ps[3] = 1;
        req_valid[1] = 1'b1; req_valid[3] = 1'b1;
        step(h);
        chk("t5_grant_a", 32'(h), 1);
        req_valid[3] = 1'b0; pa[1] = -6; pb[1] = 6;
        step(h);
        chk("t5_grant_b", 32'(h), 1);
        req_valid[1] = 1'b0;
        step(h);
        chk("t5_idle", 32'(h), 32'(-1));
        repeat (2) step(h);

        // Reset with two ops in flight.
        pa[0] = 11; pb[0] = 2; pa[1] = 12; pb[1] = 3; ps[0] = 0; ps[1] = 1;
        req_valid[0] = 1'b1; req_valid[1] = 1'b1;
        step_drop(h);
        step_drop(h);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(res_valid), 0);
        chk("t6_async_busy", 32'(busy), 0);
        model_reset();
        for (int i = 0; i < N; i++) begin pa[i] = 20 + i; pb[i] = i; ps[i] = 0; end
        req_valid = '1;
        drive_ops();
        #1;
        chk("t6_rst_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step_drop(h);
        chk("t6_first_grant", 32'(h), 0);
        req_valid = '0;

        // Random traffic with random backpressure.
        for (int c = 0; c < 800; c++) begin
            step(h);
            if (h >= 0) begin
                if ($urandom_range(0, 1) != 0) new_op(h);
                else req_valid[h] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (i != h) begin
                    if (!req_valid[i]) begin
                        if ($urandom_range(0, 2) == 0) new_op(i);
                    end else if ($urandom_range(0, 15) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (LAT + 3) step(h);
        chk("end_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp32_add_arbiter.md
Name: fp32_add_arbiter

Overview:
Shares one fp32_add datapath among NUM_REQ requesters, such as force-pipeline accumulators.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registers the winning operands and pipelines result, tag and valid through a fixed LATENCY.
- Drives a single tagged result stream with global backpressure.
- Instantiates fp32_add internally. No requester drives the adder directly.

Parameters:
NUM_REQ, 4, number of requesters (1..16)
LATENCY, 2, cycles from request handshake edge to res_valid (>=1)
ID_W, max(1,$clog2(NUM_REQ)), width of res_id

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operation request
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_a  in  NUM_REQ*32  operand A, requester i at [32i+31:32i]
req_b  in  NUM_REQ*32  operand B, same packing
req_sub  in  NUM_REQ  1 = A-B, 0 = A+B
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_id  out  ID_W  index of requester that issued the result
res_data  out  32  FP32 result
busy  out  1  any pipeline stage holds a valid op

Behaviour:
- Reset (async assert, sync deassert by system) clears the following:
  - all stage valids to 0
  - operand/data/id registers to 0
  - rr pointer to NUM_REQ-1, so requester 0 has top priority first
- Reset outputs: res_valid=0, res_id=0, res_data=0x00000000, busy=0, req_ready=0.
- Stall condition: stall = res_valid & ~res_ready.
  - While stalled, every stage holds and req_ready is all-zero.
  - No bubble collapsing.
- Grant:
  - Combinational.
  - Picks the first i with req_valid[i]=1, scanning from ptr+1 upward with wrap modulo NUM_REQ.
  - req_ready[i] = grant[i] & ~stall.
- Handshake: req_valid[i] & req_ready[i] at a rising edge.
  - Captures req_a/req_b/req_sub/i into stage 1 with valid=1.
  - ptr <= i.
  - ptr changes only on a handshake.
- No handshake and not stalled: stage 1 loads valid=0 (bubble) and operand registers hold.
- Pipeline:
  - Stage 1 operand registers feed fp32_add.
  - The adder output plus id/valid pass through LATENCY-1 further register stages.
  - For LATENCY=1, res_data is the adder output of stage 1 directly.
- Timing: handshake at edge t gives res_valid=1 from edge t+LATENCY-1 onward, i.e. sampled at edge t+LATENCY, absent stall.
- Throughput: one op per cycle while res_ready=1.
- Result consumed: on res_valid & res_ready at an edge; the pipeline advances.
- Requester obligation: hold req_* stable while req_valid=1 and req_ready=0. Dropping req_valid before grant is legal and causes no side effect.
- NUM_REQ=1: grant = req_valid[0]; res_id=0.
- Arithmetic: exactly fp32_add semantics. sub passed as the op bit; no rounding or special-case handling in this block.
- busy = OR of all stage valids.
- Reset mid-operation: in-flight ops are discarded with no result emitted; the requester must reissue.

Decomposition:
- Package fp32_arb_pkg:
  - FP32_W=32
  - FP32 constants ONE=0x3F800000, TWO=0x40000000, THREE=0x40400000, FIVE=0x40A00000
  - op encoding localparams OP_ADD=0, OP_SUB=1
- Sub-module rr_arbiter (parameter N). Interface:
  - inputs req[N], advance, winner index
  - output grant one-hot
  - owns the pointer register
- The top module holds the pipeline and the fp32_add instance.

Test Plan:
1. Single add, LATENCY=2, res_ready=1:
   - Stimulus: req0 A=0x3F800000, B=0x40000000, sub=0, handshake at edge t.
   - Required response: res_valid at edge t+2 with res_data=0x40400000, res_id=0; busy falls after.
2. Subtract: req2 A=0x40A00000, B=0x40400000, sub=1 -> res_data=0x40000000, res_id=2.
3. Round-robin, all four req_valid held high with distinct operands for 8 cycles:
   - Grant order 0,1,2,3,0,1,2,3.
   - res_id sequence matches, one result per cycle, no drops.
4. Backpressure:
   - Stimulus: stream of 4 ops with res_ready=0 for 3 cycles once res_valid rises.
   - Required response: res_valid/res_id/res_data stable and req_ready all-zero during the stall. After release, results emerge in order with no duplication or loss.
5. Sparse requesters: only req1 and req3 valid, req3 deasserts before grant -> only req1 granted; ptr sequence correct.
6. Reset mid-flight:
   - Stimulus: assert rst_n=0 with 2 ops in flight.
   - Required response: res_valid=0 and busy=0 immediately (async). After release, no stale results; the next grant goes to req0.
